pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Controller for the 16-bit PC register block: decides each cycle whether the PC loads, jumps or holds, and drives its PC_E / ctrl_PC / D / PC_label inputs.
- Runs a fetch handshake with instruction memory and takes decoded flow-control strobes from the decoder.
- Owns a hardware return-address stack for call/return.
- Sits between the decoder and PC register in the RISC CPU top level.

Parameters:
- DEPTH, 4, return-stack entries (2..16).
- RESET_VEC, 16'h0000, PC value loaded on leaving IDLE.

Ports:
- CLK  in  1  system clock, rising edge.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- run  in  1  start request; sampled in IDLE and HALT.
- pc_q  in  16  current PC (PC register Q output).
- fetch_req  out  1  instruction fetch request, held until ack.
- fetch_ack  in  1  memory: instruction and decode strobes valid this cycle.
- op_jump  in  1  decoded jump.
- op_call  in  1  decoded call.
- op_ret  in  1  decoded return.
- op_halt  in  1  decoded halt.
- op_label  in  11  jump/call target (low PC bits).
- stall  in  1  pipeline stall; holds UPDATE.
- PC_E  out  1  PC register write enable.
- ctrl_PC  out  1  0 = load D, 1 = load {PC[15:11], PC_label}.
- D  out  16  full PC load value.
- PC_label  out  11  jump label.
- halted  out  1  high in HALT.
- stk_ovf  out  1  sticky: call with stack full.
- stk_unf  out  1  sticky: return with stack empty.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, stack pointer 0. rst wins over every other input on the same edge, in any state, including mid-handshake.
- FSM states: IDLE, INIT, FETCH, UPDATE, HALT.
- IDLE:
  - Outputs 0.
  - run=1 -> INIT.
- INIT (1 cycle):
  - PC_E=1, ctrl_PC=0, D=RESET_VEC.
  - -> FETCH.
- FETCH:
  - fetch_req=1 from the first cycle in FETCH until the cycle fetch_ack=1, inclusive.
  - On ack, register op_* and op_label -> UPDATE. Op inputs are ignored outside ack cycles.
- UPDATE:
  - While stall=1: PC_E=0, stay.
  - When stall=0: PC_E=1 for exactly one cycle, then -> FETCH, or -> HALT if op_halt was latched.
  - Action priority: halt > ret > call > jump > increment.
  - halt: PC_E=0 and the PC holds; the halt is the last instruction.
  - ret, stack non-empty: pop; ctrl_PC=0, D=popped value.
  - ret, stack empty: set stk_unf; perform increment instead.
  - call: push pc_q+1 (mod 2^16); ctrl_PC=1, PC_label=op_label.
  - call, stack full: set stk_ovf; no push; the jump is still taken.
  - jump: ctrl_PC=1, PC_label=op_label.
  - increment: ctrl_PC=0, D=pc_q+1; 16'hFFFF wraps to 16'h0000.
- HALT:
  - halted=1, PC_E=0.
  - run=1 -> FETCH with PC unchanged, halted clears.
- Output timing:
  - PC_E, ctrl_PC, D and PC_label are registered and valid in the same cycle.
  - The PC register updates on the edge that ends the PC_E cycle, so the new pc_q is visible in the next FETCH.
- Stack: LIFO of DEPTH x 16 bits.
  - Pointer range 0..DEPTH.
  - Only one push or pop per UPDATE.
  - Cleared only by rst.
- stk_ovf and stk_unf stay set until rst.

Optional Feature:
- Macro: PCSEQ_TRAP_EN.
- Defined:
  - Parameter TRAP_VEC, default 16'h0010, is added.
  - Any call that overflows, or return that underflows, instead loads D=TRAP_VEC with ctrl_PC=0.
  - Stack contents are unchanged.
  - The sticky flag is still set.
- Undefined: overflow/underflow behaviour exactly as given under Behaviour; TRAP_VEC does not exist.

Test Plan:
- Start/increment: rst 2 cycles; run=1; RESET_VEC=16'h0000.
  - Expect INIT PC_E pulse, D=0000.
  - After 3 acked plain fetches, PC=0003; fetch_req drops on the ack cycle.
- Jump/wrap:
  - pc_q=16'hA7F0, op_jump with op_label=11'h123 -> PC=16'hA123.
  - Later pc_q=16'hFFFF with increment -> PC=16'h0000.
- Call/return:
  - At pc_q=16'h0040, call to label 11'h200 -> PC=0200.
  - Then a return -> PC=0041.
  - Stack empty afterwards; stk_ovf=0, stk_unf=0.
- Stack limits (DEPTH=4):
  - 5 nested calls -> stk_ovf=1 on the 5th, and the 5th jump is taken.
  - 5 returns -> 4 correct pops, then stk_unf=1 and PC increments.
  - With PCSEQ_TRAP_EN defined, the 5th call loads PC=0010 instead.
- Stall/halt:
  - stall=1 for 3 cycles in UPDATE -> no PC_E during the stall, exactly one PC_E after.
  - op_halt -> halted=1 and PC holds for 10 cycles; run=1 -> fetch resumes at the same PC.
- Reset mid-operation: assert rst while fetch_req=1 and the stack holds 2 entries.
  - Next cycle: all outputs 0, state IDLE.
  - After run, a return gives stk_unf=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// PC register controller: fetch handshake, flow-control decode, and return-address stack.
// Optional PCSEQ_TRAP_EN: stack overflow/underflow redirects the PC to TRAP_VEC.
module pc_sequencer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] RESET_VEC = 16'h0000
`ifdef PCSEQ_TRAP_EN
  , parameter logic [15:0] TRAP_VEC = 16'h0010
`endif
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] pc_q,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic        op_jump,
  input  logic        op_call,
  input  logic        op_ret,
  input  logic        op_halt,
  input  logic [10:0] op_label,
  input  logic        stall,
  output logic        PC_E,
  output logic        ctrl_PC,
  output logic [15:0] D,
  output logic [10:0] PC_label,
  output logic        halted,
  output logic        stk_ovf,
  output logic        stk_unf
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned IW  = $clog2(DEPTH);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_FETCH, S_UPDATE, S_HALT} state_t;

  state_t         state, next_state;
  logic [SPW-1:0] sp;
  logic [15:0]    stack [DEPTH];
  logic           l_jump, l_call, l_ret, l_halt;
  logic [10:0]    l_label;

  logic           pe_nxt, ctrl_nxt, push, pop, ovf_set, unf_set;
  logic [15:0]    d_nxt;
  logic [10:0]    label_nxt;
  logic [15:0]    pc_inc;
  logic           stack_full, stack_empty;

  assign pc_inc      = pc_q + 16'd1;
  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);
  assign fetch_req   = (state == S_FETCH);
  assign halted      = (state == S_HALT);

  always_ff @(posedge CLK) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // UPDATE lasts through the registered PC_E cycle and leaves on the edge that ends it.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (run) next_state = S_INIT;
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  if (fetch_ack) next_state = S_UPDATE;
      S_UPDATE: begin
        if (PC_E)                  next_state = S_FETCH;
        else if (!stall && l_halt) next_state = S_HALT;
      end
      S_HALT:   if (run) next_state = S_FETCH;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    pe_nxt    = 1'b0;
    ctrl_nxt  = 1'b0;
    d_nxt     = '0;
    label_nxt = '0;
    push      = 1'b0;
    pop       = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (state == S_IDLE && run) begin
      pe_nxt = 1'b1;
      d_nxt  = RESET_VEC;
    end else if (state == S_UPDATE && !PC_E && !stall && !l_halt) begin
      pe_nxt = 1'b1;
      if (l_ret) begin
        if (!stack_empty) begin
          pop   = 1'b1;
          d_nxt = stack[IW'(sp - SP_ONE)];
        end else begin
          unf_set = 1'b1;
`ifdef PCSEQ_TRAP_EN
          d_nxt = TRAP_VEC;
`else
          d_nxt = pc_inc;
`endif
        end
      end else if (l_call) begin
        if (!stack_full) begin
          push      = 1'b1;
          ctrl_nxt  = 1'b1;
          label_nxt = l_label;
        end else begin
          ovf_set = 1'b1;
`ifdef PCSEQ_TRAP_EN
          d_nxt = TRAP_VEC;
`else
          ctrl_nxt  = 1'b1;
          label_nxt = l_label;
`endif
        end
      end else if (l_jump) begin
        ctrl_nxt  = 1'b1;
        label_nxt = l_label;
      end else begin
        d_nxt = pc_inc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      PC_E     <= 1'b0;
      ctrl_PC  <= 1'b0;
      D        <= '0;
      PC_label <= '0;
      stk_ovf  <= 1'b0;
      stk_unf  <= 1'b0;
      sp       <= '0;
      l_jump   <= 1'b0;
      l_call   <= 1'b0;
      l_ret    <= 1'b0;
      l_halt   <= 1'b0;
      l_label  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      PC_E     <= pe_nxt;
      ctrl_PC  <= ctrl_nxt;
      D        <= d_nxt;
      PC_label <= label_nxt;
      stk_ovf  <= stk_ovf | ovf_set;
      stk_unf  <= stk_unf | unf_set;
      if (state == S_FETCH && fetch_ack) begin
        l_jump  <= op_jump;
        l_call  <= op_call;
        l_ret   <= op_ret;
        l_halt  <= op_halt;
        l_label <= op_label;
      end
      if (push) begin
        stack[IW'(sp)] <= pc_inc;
        sp             <= sp + SP_ONE;
      end else if (pop) begin
        sp <= sp - SP_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; models the external PC register it drives.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        rst, run, fetch_ack, op_jump, op_call, op_ret, op_halt, stall;
  logic [15:0] pc_q;
  logic [10:0] op_label;
  logic        fetch_req, PC_E, ctrl_PC, halted, stk_ovf, stk_unf;
  logic [15:0] D;
  logic [10:0] PC_label;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pc_sequencer #(.DEPTH(4), .RESET_VEC(16'h0000)) dut (
    .CLK(CLK), .rst(rst), .run(run), .pc_q(pc_q),
    .fetch_req(fetch_req), .fetch_ack(fetch_ack),
    .op_jump(op_jump), .op_call(op_call), .op_ret(op_ret), .op_halt(op_halt),
    .op_label(op_label), .stall(stall),
    .PC_E(PC_E), .ctrl_PC(ctrl_PC), .D(D), .PC_label(PC_label),
    .halted(halted), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock; the modelled PC register loads on the edge if PC_E was high before it.
  task automatic tick;
    logic        pe, cp;
    logic [15:0] dd;
    logic [10:0] ll;
    pe = PC_E; cp = ctrl_PC; dd = D; ll = PC_label;
    @(posedge CLK);
    #1;
    if (pe === 1'b1) pc_q = cp ? {pc_q[15:11], ll} : dd;
  endtask

  task automatic wait_fetch(input string tag);
    int n = 0;
    while (fetch_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, "_fetch_wait"}, 32'(fetch_req), 32'h1);
  endtask

  task automatic do_instr(input string tag, input logic j, input logic c, input logic r,
                          input logic h, input logic [10:0] lbl, input int stalls,
                          input logic [15:0] exp_pc);
    int pulses = 0;
    int stall_pulses = 0;
    int n = 0;
    wait_fetch(tag);
    op_jump = j; op_call = c; op_ret = r; op_halt = h; op_label = lbl;
    fetch_ack = 1'b1;
    stall = (stalls > 0);
    tick();
    fetch_ack = 1'b0;
    op_jump = 1'b0; op_ret = 1'b0; op_halt = 1'b0;
    op_call = 1'b1; op_label = '1;
    check_val({tag, "_req_drop"}, 32'(fetch_req), 32'h0);
    for (int i = 0; i < stalls; i++) begin
      tick();
      if (PC_E === 1'b1) stall_pulses++;
    end
    if (stalls > 0) check_val({tag, "_stall_pe"}, 32'(stall_pulses), 32'h0);
    stall = 1'b0;
    while (n < 8 && fetch_req !== 1'b1 && halted !== 1'b1) begin
      tick();
      n++;
      if (PC_E === 1'b1) pulses++;
    end
    op_call = 1'b0; op_label = '0;
    check_val({tag, "_pulses"}, 32'(pulses), h ? 32'h0 : 32'h1);
    check_val({tag, "_pc"}, 32'(pc_q), 32'(exp_pc));
  endtask

  initial begin
    int pe_cnt;
    rst = 1'b1; run = 1'b0; fetch_ack = 1'b0; stall = 1'b0;
    op_jump = 1'b0; op_call = 1'b0; op_ret = 1'b0; op_halt = 1'b0; op_label = '0;
    pc_q = 16'h5555;
    tick(); tick();
    check_val("rst_pe", 32'(PC_E), 32'h0);
    check_val("rst_req", 32'(fetch_req), 32'h0);
    check_val("rst_halted", 32'(halted), 32'h0);
    check_val("rst_d", 32'(D), 32'h0);
    check_val("rst_flags", 32'({stk_ovf, stk_unf}), 32'h0);
    rst = 1'b0;
    tick();
    check_val("idle_hold", 32'(fetch_req), 32'h0);

    run = 1'b1;
    tick();
    check_val("init_pe", 32'(PC_E), 32'h1);
    check_val("init_ctrl", 32'(ctrl_PC), 32'h0);
    check_val("init_d", 32'(D), 32'h0);
    run = 1'b0;
    tick();
    check_val("init_pc", 32'(pc_q), 32'h0);
    check_val("init_req", 32'(fetch_req), 32'h1);

    do_instr("inc1", 0, 0, 0, 0, 11'h0, 0, 16'h0001);
    do_instr("inc2", 0, 0, 0, 0, 11'h0, 0, 16'h0002);
    do_instr("inc3", 0, 0, 0, 0, 11'h0, 0, 16'h0003);

    pc_q = 16'hA7F0;
    do_instr("jump", 1, 0, 0, 0, 11'h123, 0, 16'hA123);
    pc_q = 16'hFFFF;
    do_instr("wrap", 0, 0, 0, 0, 11'h0, 0, 16'h0000);

    pc_q = 16'h0040;
    do_instr("call", 0, 1, 0, 0, 11'h200, 0, 16'h0200);
    do_instr("ret", 0, 0, 1, 0, 11'h0, 0, 16'h0041);
    check_val("cr_flags", 32'({stk_ovf, stk_unf}), 32'h0);

    pc_q = 16'h0100;
    do_instr("nest1", 0, 1, 0, 0, 11'h101, 0, 16'h0101);
    do_instr("nest2", 0, 1, 0, 0, 11'h102, 0, 16'h0102);
    do_instr("nest3", 0, 1, 0, 0, 11'h103, 0, 16'h0103);
    do_instr("nest4", 0, 1, 0, 0, 11'h104, 0, 16'h0104);
    check_val("ovf_before", 32'(stk_ovf), 32'h0);
`ifdef PCSEQ_TRAP_EN
    do_instr("nest5", 0, 1, 0, 0, 11'h105, 0, 16'h0010);
`else
    do_instr("nest5", 0, 1, 0, 0, 11'h105, 0, 16'h0105);
`endif
    check_val("ovf_after", 32'(stk_ovf), 32'h1);
    do_instr("pop1", 0, 0, 1, 0, 11'h0, 0, 16'h0104);
    do_instr("pop2", 0, 0, 1, 0, 11'h0, 0, 16'h0103);
    do_instr("pop3", 0, 0, 1, 0, 11'h0, 0, 16'h0102);
    do_instr("pop4", 0, 0, 1, 0, 11'h0, 0, 16'h0101);
    check_val("unf_before", 32'(stk_unf), 32'h0);
`ifdef PCSEQ_TRAP_EN
    do_instr("pop5", 0, 0, 1, 0, 11'h0, 0, 16'h0010);
`else
    do_instr("pop5", 0, 0, 1, 0, 11'h0, 0, 16'h0102);
`endif
    check_val("unf_after", 32'(stk_unf), 32'h1);

    pc_q = 16'h0300;
    do_instr("stall", 0, 0, 0, 0, 11'h0, 3, 16'h0301);

    do_instr("halt", 0, 0, 0, 1, 11'h0, 0, 16'h0301);
    check_val("halted", 32'(halted), 32'h1);
    pe_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (PC_E === 1'b1) pe_cnt++;
    end
    check_val("halt_pe", 32'(pe_cnt), 32'h0);
    check_val("halt_pc", 32'(pc_q), 32'h0301);
    check_val("halt_hold", 32'(halted), 32'h1);
    run = 1'b1;
    tick();
    run = 1'b0;
    check_val("resume_halted", 32'(halted), 32'h0);
    check_val("resume_req", 32'(fetch_req), 32'h1);
    do_instr("resume", 0, 0, 0, 0, 11'h0, 0, 16'h0302);

    pc_q = 16'h0500;
    do_instr("rcall1", 0, 1, 0, 0, 11'h600, 0, 16'h0600);
    do_instr("rcall2", 0, 1, 0, 0, 11'h610, 0, 16'h0610);
    wait_fetch("mid_rst");
    op_ret = 1'b1; fetch_ack = 1'b1; rst = 1'b1;
    tick();
    op_ret = 1'b0; fetch_ack = 1'b0; rst = 1'b0;
    check_val("mrst_pe", 32'(PC_E), 32'h0);
    check_val("mrst_req", 32'(fetch_req), 32'h0);
    check_val("mrst_outs", 32'({ctrl_PC, D, PC_label}), 32'h0);
    check_val("mrst_flags", 32'({halted, stk_ovf, stk_unf}), 32'h0);
    tick();
    check_val("mrst_idle", 32'(fetch_req), 32'h0);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    check_val("mrst_pc", 32'(pc_q), 32'h0);
`ifdef PCSEQ_TRAP_EN
    do_instr("mrst_ret", 0, 0, 1, 0, 11'h0, 0, 16'h0010);
`else
    do_instr("mrst_ret", 0, 0, 1, 0, 11'h0, 0, 16'h0001);
`endif
    check_val("mrst_unf", 32'(stk_unf), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
